// File: rtl/oneshot_voice_arbiter.sv
// Oneshot voice arbiter: maps drum-pad triggers onto a small pool of shared
// oneshot voices with round-robin requester service, in-place retrigger,
// idle-voice allocation and oldest-voice stealing.
module oneshot_voice_arbiter #(
    parameter int unsigned NUM_REQ       = 4,
    parameter int unsigned NUM_VOICES    = 2,
    parameter int unsigned FREQ_RES_BITS = 8,
    parameter int unsigned AGE_BITS      = 16,
    localparam int unsigned OWNER_BITS   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                                  mclk,
    input  logic                                  reset,
    input  logic                                  pblrc,
    input  logic [NUM_REQ-1:0]                    req,
    input  logic [NUM_REQ*FREQ_RES_BITS-1:0]      req_freq,
    input  logic [NUM_VOICES-1:0]                 voice_done,
    output logic [NUM_VOICES-1:0]                 voice_trig,
    output logic [NUM_VOICES*FREQ_RES_BITS-1:0]   voice_freq,
    output logic [NUM_VOICES-1:0]                 voice_busy,
    output logic [NUM_VOICES*OWNER_BITS-1:0]      voice_owner,
    output logic [7:0]                            steal_count
);

    localparam int unsigned VSEL_BITS = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } vstate_t;

    vstate_t                 state [NUM_VOICES];
    logic [AGE_BITS-1:0]     age   [NUM_VOICES];
    logic [NUM_REQ-1:0]      pending;
    logic [OWNER_BITS-1:0]   rr_ptr;
    logic                    pblrc_q;

    logic                     cand_valid;
    logic [OWNER_BITS-1:0]    cand;
    logic [FREQ_RES_BITS-1:0] cand_freq;
    logic [NUM_REQ-1:0]       grant_req;
    logic                     hit;
    logic                     steal;
    logic [VSEL_BITS-1:0]     sel;
    logic [AGE_BITS-1:0]      best_age;
    logic [NUM_VOICES-1:0]    grant_voice;
    logic                     sample_tick;

    assign sample_tick = pblrc & ~pblrc_q;

    // Round-robin candidate: first pending index strictly after the pointer, then wrap
    always_comb begin
        cand_valid = 1'b0;
        cand       = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (!cand_valid && pending[i] && (OWNER_BITS'(i) > rr_ptr)) begin
                cand_valid = 1'b1;
                cand       = OWNER_BITS'(i);
            end
        end
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (!cand_valid && pending[i] && (OWNER_BITS'(i) <= rr_ptr)) begin
                cand_valid = 1'b1;
                cand       = OWNER_BITS'(i);
            end
        end
        cand_freq = '0;
        grant_req = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (cand == OWNER_BITS'(i)) begin
                cand_freq    = req_freq[i*FREQ_RES_BITS +: FREQ_RES_BITS];
                grant_req[i] = cand_valid;
            end
        end
    end

    // Voice choice: retrigger own voice, else lowest idle, else steal the oldest
    always_comb begin
        hit      = 1'b0;
        steal    = 1'b0;
        sel      = '0;
        best_age = '0;
        for (int v = 0; v < int'(NUM_VOICES); v++) begin
            if (!hit && (state[v] == ACTIVE) &&
                (voice_owner[v*OWNER_BITS +: OWNER_BITS] == cand)) begin
                hit = 1'b1;
                sel = VSEL_BITS'(v);
            end
        end
        for (int v = 0; v < int'(NUM_VOICES); v++) begin
            if (!hit && (state[v] == IDLE)) begin
                hit = 1'b1;
                sel = VSEL_BITS'(v);
            end
        end
        if (!hit) begin
            steal    = 1'b1;
            best_age = age[0];
            for (int v = 1; v < int'(NUM_VOICES); v++) begin
                if (age[v] > best_age) begin
                    best_age = age[v];
                    sel      = VSEL_BITS'(v);
                end
            end
        end
        grant_voice = '0;
        for (int v = 0; v < int'(NUM_VOICES); v++) begin
            grant_voice[v] = cand_valid && (sel == VSEL_BITS'(v));
        end
    end

    // Pending bits, pointer, per-voice FSMs, ages and steal counter
    always_ff @(posedge mclk or negedge reset) begin
        if (!reset) begin
            pending     <= '0;
            rr_ptr      <= OWNER_BITS'(NUM_REQ - 1);
            pblrc_q     <= 1'b0;
            steal_count <= 8'd0;
            voice_trig  <= '0;
            voice_busy  <= '0;
            voice_freq  <= '0;
            voice_owner <= '0;
            for (int v = 0; v < int'(NUM_VOICES); v++) begin
                state[v] <= IDLE;
                age[v]   <= '0;
            end
        end else begin
            pblrc_q    <= pblrc;
            pending    <= (pending & ~grant_req) | req;
            voice_trig <= grant_voice;
            if (cand_valid) begin
                rr_ptr <= cand;
            end
            if (cand_valid && steal && (steal_count != 8'hFF)) begin
                steal_count <= steal_count + 8'd1;
            end
            for (int v = 0; v < int'(NUM_VOICES); v++) begin
                if (grant_voice[v]) begin
                    state[v]       <= ACTIVE;
                    voice_busy[v]  <= 1'b1;
                    age[v]         <= '0;
                    voice_freq[v*FREQ_RES_BITS +: FREQ_RES_BITS] <= cand_freq;
                    voice_owner[v*OWNER_BITS +: OWNER_BITS]      <= cand;
                end else if (state[v] == ACTIVE) begin
                    if (voice_done[v]) begin
                        state[v]      <= IDLE;
                        voice_busy[v] <= 1'b0;
                    end
                    if (sample_tick && (age[v] != '1)) begin
                        age[v] <= age[v] + AGE_BITS'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_oneshot_voice_arbiter.sv
// Directed self-checking bench for oneshot_voice_arbiter (default parameters).
module tb_oneshot_voice_arbiter;

    logic        mclk = 1'b0;
    logic        reset;
    logic        pblrc;
    logic [3:0]  req;
    logic [31:0] req_freq;
    logic [1:0]  voice_done;
    logic [1:0]  voice_trig;
    logic [15:0] voice_freq;
    logic [1:0]  voice_busy;
    logic [3:0]  voice_owner;
    logic [7:0]  steal_count;

    int checks = 0;
    int errors = 0;

    oneshot_voice_arbiter dut (
        .mclk        (mclk),
        .reset       (reset),
        .pblrc       (pblrc),
        .req         (req),
        .req_freq    (req_freq),
        .voice_done  (voice_done),
        .voice_trig  (voice_trig),
        .voice_freq  (voice_freq),
        .voice_busy  (voice_busy),
        .voice_owner (voice_owner),
        .steal_count (steal_count)
    );

    always #5 mclk = ~mclk;

    task automatic tick();
        @(posedge mclk);
        @(negedge mclk);
    endtask

    task automatic do_reset();
        reset      = 1'b0;
        req        = '0;
        voice_done = '0;
        pblrc      = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic pblrc_edges(input int n);
        repeat (n) begin
            pblrc = 1'b1;
            tick();
            pblrc = 1'b0;
            tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; req = '0; voice_done = '0; pblrc = 1'b0; req_freq = '0;
        #1;
        checks++;
        if ({voice_trig, voice_busy, voice_freq, voice_owner, steal_count} !== 34'd0) begin
            errors++;
            $display("FAIL reset_outputs: got trig=%b busy=%b freq=%h owner=%h steals=%0d, want all zero",
                     voice_trig, voice_busy, voice_freq, voice_owner, steal_count);
        end
        do_reset();
    endtask

    task automatic test_single_grant();
        do_reset();
        req_freq[7:0] = 8'd48;
        req = 4'b0001;
        tick();
        req = 4'b0000;
        checks++;
        if (voice_trig !== 2'b00) begin
            errors++; $display("FAIL single_early_trig: got %b want 00", voice_trig);
        end
        tick();
        checks++;
        if (voice_trig !== 2'b01 || voice_freq[7:0] !== 8'd48 || voice_owner[1:0] !== 2'd0 || voice_busy !== 2'b01) begin
            errors++;
            $display("FAIL single_grant: got trig=%b freq0=%0d owner0=%0d busy=%b want 01/48/0/01",
                     voice_trig, voice_freq[7:0], voice_owner[1:0], voice_busy);
        end
        tick();
        checks++;
        if (voice_trig !== 2'b00 || voice_busy !== 2'b01) begin
            errors++; $display("FAIL single_pulse_width: got trig=%b busy=%b want 00/01", voice_trig, voice_busy);
        end
    endtask

    task automatic test_all_four();
        do_reset();
        req_freq = {8'd13, 8'd12, 8'd11, 8'd10};
        req = 4'b1111;
        tick();
        req = 4'b0000;
        tick();
        checks++;
        if (voice_trig !== 2'b01 || voice_owner[1:0] !== 2'd0) begin
            errors++; $display("FAIL rr_grant0: got trig=%b owner0=%0d want 01/0", voice_trig, voice_owner[1:0]);
        end
        tick();
        checks++;
        if (voice_trig !== 2'b10 || voice_owner[3:2] !== 2'd1 || steal_count !== 8'd0) begin
            errors++; $display("FAIL rr_grant1: got trig=%b owner1=%0d steals=%0d want 10/1/0",
                               voice_trig, voice_owner[3:2], steal_count);
        end
        pblrc = 1'b1;
        tick();
        checks++;
        if (voice_trig !== 2'b01 || voice_owner[1:0] !== 2'd2 || steal_count !== 8'd1) begin
            errors++; $display("FAIL rr_grant2_steal: got trig=%b owner0=%0d steals=%0d want 01/2/1",
                               voice_trig, voice_owner[1:0], steal_count);
        end
        tick();
        pblrc = 1'b0;
        checks++;
        if (voice_trig !== 2'b10 || voice_owner !== 4'b1110 || steal_count !== 8'd2 || voice_freq !== {8'd13, 8'd12}) begin
            errors++; $display("FAIL rr_grant3_steal: got trig=%b owners=%b steals=%0d freq=%h want 10/1110/2/0d0c",
                               voice_trig, voice_owner, steal_count, voice_freq);
        end
    endtask

    task automatic test_age_steal();
        do_reset();
        req_freq = {8'd40, 8'd30, 8'd20, 8'd10};
        req = 4'b0010; tick(); req = 4'b0000; tick();
        pblrc_edges(7);
        req = 4'b0100; tick(); req = 4'b0000; tick();
        checks++;
        if (voice_busy !== 2'b11 || voice_owner !== 4'b1001) begin
            errors++; $display("FAIL age_setup: got busy=%b owners=%b want 11/1001", voice_busy, voice_owner);
        end
        pblrc_edges(3);
        req = 4'b1000; tick(); req = 4'b0000; tick();
        checks++;
        if (voice_trig !== 2'b01 || voice_owner[1:0] !== 2'd3 || steal_count !== 8'd1) begin
            errors++; $display("FAIL age_steal_oldest: got trig=%b owner0=%0d steals=%0d want 01/3/1",
                               voice_trig, voice_owner[1:0], steal_count);
        end
        req = 4'b0100; tick(); req = 4'b0000; tick();
        checks++;
        if (voice_trig !== 2'b10 || voice_owner !== 4'b1011 || steal_count !== 8'd1) begin
            errors++; $display("FAIL retrigger_in_place: got trig=%b owners=%b steals=%0d want 10/1011/1",
                               voice_trig, voice_owner, steal_count);
        end
    endtask

    task automatic test_done();
        do_reset();
        req_freq = {8'h00, 8'h44, 8'h33, 8'h21};
        req = 4'b0001; tick(); req = 4'b0000; tick();
        pblrc_edges(5);
        req = 4'b0010; tick(); req = 4'b0000; tick();
        pblrc_edges(2);
        req = 4'b0001; tick(); req = 4'b0000;
        voice_done = 2'b01;
        tick();
        voice_done = 2'b00;
        checks++;
        if (voice_busy !== 2'b11 || voice_trig !== 2'b01) begin
            errors++; $display("FAIL done_vs_grant: got busy=%b trig=%b want 11/01", voice_busy, voice_trig);
        end
        tick();
        checks++;
        if (voice_busy !== 2'b11) begin
            errors++; $display("FAIL done_vs_grant_hold: got busy=%b want 11", voice_busy);
        end
        req = 4'b0100; tick(); req = 4'b0000; tick();
        checks++;
        if (voice_trig !== 2'b10 || voice_owner[3:2] !== 2'd2 || steal_count !== 8'd1) begin
            errors++; $display("FAIL age_cleared_on_grant: got trig=%b owner1=%0d steals=%0d want 10/2/1",
                               voice_trig, voice_owner[3:2], steal_count);
        end
        voice_done = 2'b10; tick(); voice_done = 2'b00;
        checks++;
        if (voice_busy !== 2'b01) begin
            errors++; $display("FAIL done_to_idle: got busy=%b want 01", voice_busy);
        end
        voice_done = 2'b10; tick(); voice_done = 2'b00;
        checks++;
        if (voice_busy !== 2'b01 || voice_owner[3:2] !== 2'd2 || voice_freq[15:8] !== 8'h44 || voice_trig !== 2'b00) begin
            errors++; $display("FAIL done_on_idle: got busy=%b owner1=%0d freq1=%h trig=%b want 01/2/44/00",
                               voice_busy, voice_owner[3:2], voice_freq[15:8], voice_trig);
        end
    endtask

    task automatic test_saturate_and_reset();
        logic [1:0] trig_seen;
        do_reset();
        req_freq = {8'd4, 8'd3, 8'd2, 8'd1};
        req = 4'b1111;
        repeat (450) tick();
        checks++;
        if (steal_count !== 8'd255) begin
            errors++; $display("FAIL steal_saturate: got %0d want 255", steal_count);
        end
        @(posedge mclk);
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({voice_trig, voice_busy, voice_freq, voice_owner, steal_count} !== 34'd0) begin
            errors++; $display("FAIL async_reset: got trig=%b busy=%b freq=%h owner=%h steals=%0d want all zero",
                               voice_trig, voice_busy, voice_freq, voice_owner, steal_count);
        end
        req = 4'b0000;
        trig_seen = '0;
        @(negedge mclk);
        repeat (3) begin tick(); trig_seen |= voice_trig; end
        reset = 1'b1;
        repeat (3) begin tick(); trig_seen |= voice_trig; end
        checks++;
        if (trig_seen !== 2'b00) begin
            errors++; $display("FAIL no_trig_after_reset: got %b want 00", trig_seen);
        end
        req_freq[7:0] = 8'h5A;
        req = 4'b0001; tick(); req = 4'b0000;
        checks++;
        if (voice_trig !== 2'b00) begin
            errors++; $display("FAIL post_reset_early: got %b want 00", voice_trig);
        end
        tick();
        checks++;
        if (voice_trig !== 2'b01 || voice_freq[7:0] !== 8'h5A || voice_busy !== 2'b01) begin
            errors++; $display("FAIL post_reset_grant: got trig=%b freq0=%h busy=%b want 01/5a/01",
                               voice_trig, voice_freq[7:0], voice_busy);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        req_freq = {8'd0, 8'd0, 8'd77, 8'd0};
        req = 4'b0010;
        tick();
        tick();
        req = 4'b0000;
        checks++;
        if (voice_trig !== 2'b01 || voice_owner[1:0] !== 2'd1 || voice_freq[7:0] !== 8'd77) begin
            errors++; $display("FAIL b2b_first: got trig=%b owner0=%0d freq0=%0d want 01/1/77",
                               voice_trig, voice_owner[1:0], voice_freq[7:0]);
        end
        tick();
        checks++;
        if (voice_trig !== 2'b01 || voice_busy !== 2'b01 || steal_count !== 8'd0) begin
            errors++; $display("FAIL b2b_second: got trig=%b busy=%b steals=%0d want 01/01/0",
                               voice_trig, voice_busy, steal_count);
        end
        tick();
        checks++;
        if (voice_trig !== 2'b00) begin
            errors++; $display("FAIL b2b_no_third: got trig=%b want 00", voice_trig);
        end
    endtask

    initial begin
        test_reset();
        test_single_grant();
        test_all_four();
        test_age_steal();
        test_done();
        test_saturate_and_reset();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule

// File: doc/oneshot_voice_arbiter.md
ONESHOT_VOICE_ARBITER -- requirements
Module: oneshot_voice_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of trigger requesters (drum pads).
REQ-002 Parameter NUM_VOICES, default 2: number of shared oneshot voice datapaths (player + enveloper + volume_adjust) under control.
REQ-003 Parameter FREQ_RES_BITS, default 8: width of the frequency word forwarded to a voice's player.
REQ-004 Parameter AGE_BITS, default 16: width of the per-voice age counter, counted in samples.
REQ-005 mclk  in  1  master clock (256x sample rate); sole clock; all state updates on posedge mclk.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 pblrc  in  1  sample-rate clock, sampled as data in the mclk domain; rising edge marks one sample tick.
REQ-008 req  in  NUM_REQ  debounced trigger per requester; each high mclk cycle is one trigger.
REQ-009 req_freq  in  NUM_REQ x FREQ_RES_BITS  frequency word per requester, captured at grant.
REQ-010 voice_done  in  NUM_VOICES  one-cycle pulse from a voice's enveloper when its decay reaches zero.
REQ-011 voice_trig  out  NUM_VOICES  one-cycle start pulse to a voice's enveloper.
REQ-012 voice_freq  out  NUM_VOICES x FREQ_RES_BITS  registered frequency word per voice.
REQ-013 voice_busy  out  NUM_VOICES  voice is ACTIVE.
REQ-014 voice_owner  out  NUM_VOICES x clog2(NUM_REQ)  index of the requester last granted the voice.
REQ-015 steal_count  out  8  saturating count of voice steals since reset.

Function
REQ-016 Each voice has a two-state FSM, IDLE and ACTIVE; IDLE -> ACTIVE on grant; ACTIVE -> IDLE on voice_done with no same-cycle grant to that voice; a grant to an ACTIVE voice leaves it ACTIVE.
REQ-017 Pending register: req[i] high at posedge sets pending[i]; a second req[i] while pending[i] is set is coalesced, not counted.
REQ-018 At most one grant per mclk cycle; candidate is the pending requester nearest after the last granted index, round-robin, wrapping NUM_REQ-1 -> 0; pointer resets to NUM_REQ-1, so requester 0 is served first.
REQ-019 Voice selection, first match wins: (a) ACTIVE voice whose voice_owner equals the candidate (retrigger in place); (b) lowest-index IDLE voice; (c) steal: voice with largest age, ties to lowest index.
REQ-020 On grant at posedge N: pending[candidate] cleared, voice_trig[v] high for the cycle after N only, voice_freq[v] <= req_freq[candidate], voice_owner[v] <= candidate, age[v] <= 0, voice_busy[v] high.
REQ-021 Latency: isolated req high in cycle before posedge N -> pending at N -> voice_trig high after posedge N+1 (2 mclk).
REQ-022 A req[i] arriving the same cycle pending[i] is cleared by grant re-sets pending[i] (trigger not lost).
REQ-023 Steal (rule c) increments steal_count, saturating at 255; retrigger in place (rule a) is not a steal.
REQ-024 Age: on each pblrc rising edge (pblrc high now, low in previous mclk sample), age of every ACTIVE voice increments by 1, saturating at 2^AGE_BITS-1; IDLE voice age holds.
REQ-025 Same-cycle voice_done[v] and grant to v: grant wins, voice stays ACTIVE, age cleared.
REQ-026 voice_done on an IDLE voice is ignored.
REQ-027 voice_freq[v] holds its value after the voice goes IDLE.

Reset
REQ-028 reset low asynchronously forces: pending 0, all voices IDLE, voice_trig 0, voice_busy 0, voice_freq 0, voice_owner 0, age 0, steal_count 0, round-robin pointer NUM_REQ-1, pblrc edge-detect history 0.
REQ-029 Reset asserted mid-operation aborts all voices with no voice_trig issued; first grant after release follows REQ-021.

Verification
REQ-030 Defaults; req=0001, req_freq[0]=48 -> voice_trig=01 two mclk later, voice_freq[0]=48, voice_owner[0]=0, voice_busy=01.
REQ-031 req=1111 in one cycle -> grants on 4 consecutive cycles to requesters 0,1,2,3; voices 0,1 then steals; steal_count=2; final owners: voice0=2, voice1=3.
REQ-032 Voice0 ACTIVE, owner 1, 10 pblrc edges; voice1 ACTIVE, owner 2, 3 edges; req from requester 3 -> voice0 stolen, steal_count +1; req from requester 2 -> voice1 retriggered, steal_count unchanged.
REQ-033 voice_done[0] and a grant to voice 0 in the same cycle -> voice_busy[0] stays 1, age[0]=0; voice_done[1] on an IDLE voice 1 -> no change.
REQ-034 300 forced steals -> steal_count saturates at 255; reset low mid-grant -> all outputs 0 immediately, no voice_trig pulse.
REQ-035 req[1] pulsed in the cycle its pending bit is granted -> second grant to requester 1 follows; no trigger lost.
